// File: rtl/dr_writeback.sv
// dr_writeback: register file with a one-stage staged writeback and condition codes.
//
// A register write or CC update is staged on one rising edge (wb_addr/wb_data) and
// committed to the array and/or nzp on the next. Staging and commit overlap, so
// back-to-back writes sustain one per cycle.
//
// Configuration macro: DR_WRITEBACK_BYPASS_EN
//   defined     - reads forward the staged write data when its address matches
//   not defined - reads see array contents only; a staged write is visible after commit
//
// Ports:
//   clk        in   1      sole clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   ir_dr      in   AW     destination field
//   ir_sr1     in   AW     base/source field
//   drmux      in   2      destination select: 00 ir_dr, 01 NREG-1, 10 NREG-2, 11 ir_sr1
//   ld_reg     in   1      stage a register write
//   ld_cc      in   1      stage a condition-code update
//   bus_in     in   WIDTH  write data
//   sr1, sr2   in   AW     read addresses
//   dr         out  AW     selected destination (combinational)
//   sr1_data   out  WIDTH  read data for sr1 (combinational)
//   sr2_data   out  WIDTH  read data for sr2 (combinational)
//   nzp        out  3      registered condition codes {N,Z,P}
//   wb_pending out  1      staged write or CC update awaiting commit
module dr_writeback #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREG  = 8,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    ir_dr,
    input  logic [AW-1:0]    ir_sr1,
    input  logic [1:0]       drmux,
    input  logic             ld_reg,
    input  logic             ld_cc,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [AW-1:0]    sr1,
    input  logic [AW-1:0]    sr2,
    output logic [AW-1:0]    dr,
    output logic [WIDTH-1:0] sr1_data,
    output logic [WIDTH-1:0] sr2_data,
    output logic [2:0]       nzp,
    output logic             wb_pending
);

    logic [WIDTH-1:0] r_regfile [NREG];
    logic             r_wb_reg_v;
    logic             r_wb_cc_v;
    logic [AW-1:0]    r_wb_addr;
    logic [WIDTH-1:0] r_wb_data;
    logic [2:0]       r_nzp;
    logic [2:0]       w_nzp_next;

    // Destination select, no register stage.
    always_comb begin
        dr = ir_dr;
        unique case (drmux)
            2'b00: dr = ir_dr;
            2'b01: dr = AW'(NREG - 1);
            2'b10: dr = AW'(NREG - 2);
            2'b11: dr = ir_sr1;
            default: dr = ir_dr;
        endcase
    end

    // Condition codes derived from the staged data being committed.
    always_comb begin
        w_nzp_next = 3'b001;
        if (r_wb_data[WIDTH-1]) begin
            w_nzp_next = 3'b100;
        end else if (r_wb_data == '0) begin
            w_nzp_next = 3'b010;
        end
    end

    // Staging and commit share an edge: the commit uses the previously staged
    // values while the new ones are captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regfile[i] <= '0;
            end
            r_wb_reg_v <= 1'b0;
            r_wb_cc_v  <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_nzp      <= 3'b010;
        end else begin
            if (r_wb_reg_v) begin
                r_regfile[r_wb_addr] <= r_wb_data;
            end
            if (r_wb_cc_v) begin
                r_nzp <= w_nzp_next;
            end
            r_wb_reg_v <= ld_reg;
            r_wb_cc_v  <= ld_cc;
            if (ld_reg || ld_cc) begin
                r_wb_addr <= dr;
                r_wb_data <= bus_in;
            end
        end
    end

    always_comb begin
        sr1_data = r_regfile[sr1];
        sr2_data = r_regfile[sr2];
`ifdef DR_WRITEBACK_BYPASS_EN
        if (r_wb_reg_v && (r_wb_addr == sr1)) begin
            sr1_data = r_wb_data;
        end
        if (r_wb_reg_v && (r_wb_addr == sr2)) begin
            sr2_data = r_wb_data;
        end
`endif
    end

    assign nzp        = r_nzp;
    assign wb_pending = r_wb_reg_v | r_wb_cc_v;

endmodule

// File: tb/tb_dr_writeback.sv
// Directed self-checking bench for dr_writeback. Inputs are driven and outputs
// sampled around the falling edge; the DUT acts on rising edges.
module tb_dr_writeback;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NREG  = 8;
    localparam int unsigned AW    = 3;

`ifdef DR_WRITEBACK_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic [AW-1:0]    ir_dr;
    logic [AW-1:0]    ir_sr1;
    logic [1:0]       drmux;
    logic             ld_reg;
    logic             ld_cc;
    logic [WIDTH-1:0] bus_in;
    logic [AW-1:0]    sr1;
    logic [AW-1:0]    sr2;
    logic [AW-1:0]    dr;
    logic [WIDTH-1:0] sr1_data;
    logic [WIDTH-1:0] sr2_data;
    logic [2:0]       nzp;
    logic             wb_pending;

    int n_checks = 0;
    int n_fail   = 0;

    dr_writeback #(
        .WIDTH(WIDTH),
        .NREG (NREG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ir_dr     (ir_dr),
        .ir_sr1    (ir_sr1),
        .drmux     (drmux),
        .ld_reg    (ld_reg),
        .ld_cc     (ld_cc),
        .bus_in    (bus_in),
        .sr1       (sr1),
        .sr2       (sr2),
        .dr        (dr),
        .sr1_data  (sr1_data),
        .sr2_data  (sr2_data),
        .nzp       (nzp),
        .wb_pending(wb_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(negedge clk);
    endtask

    task automatic idle;
        ld_reg = 1'b0;
        ld_cc  = 1'b0;
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        idle();
        ir_dr  = '0;
        ir_sr1 = '0;
        drmux  = 2'b00;
        bus_in = '0;
        sr1    = '0;
        sr2    = '0;
        step();
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < int'(NREG); i++) begin
            sr1 = AW'(i);
            sr2 = AW'(NREG - 1 - i);
            #1;
            n_checks++;
            if (sr1_data !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_sr1[%0d]: got %h expected 0000", i, sr1_data);
            end
            n_checks++;
            if (sr2_data !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_sr2[%0d]: got %h expected 0000", NREG - 1 - i, sr2_data);
            end
        end
        n_checks++;
        if (nzp !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_nzp: got %b expected 010", nzp);
        end
        n_checks++;
        if (wb_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pending: got %b expected 0", wb_pending);
        end
    endtask

    // Writes via drmux 01 (link), 10 (stack) and 11 (ir_sr1).
    task automatic test_drmux;
        step();
        drmux  = 2'b01;
        ld_reg = 1'b1;
        bus_in = 16'h3000;
        sr1    = 3'd7;
        #1;
        n_checks++;
        if (dr !== 3'd7) begin
            n_fail++;
            $display("FAIL dr_link: got %0d expected 7", dr);
        end
        step();
        idle();
        #1;
        n_checks++;
        if (wb_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL link_pending: got %b expected 1", wb_pending);
        end
        n_checks++;
        if (sr1_data !== (BYPASS ? 16'h3000 : 16'h0000)) begin
            n_fail++;
            $display("FAIL link_staged_read: got %h expected %h", sr1_data,
                     BYPASS ? 16'h3000 : 16'h0000);
        end
        step();
        #1;
        n_checks++;
        if (sr1_data !== 16'h3000) begin
            n_fail++;
            $display("FAIL link_commit: got %h expected 3000", sr1_data);
        end
        n_checks++;
        if (wb_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL link_pending_clear: got %b expected 0", wb_pending);
        end

        drmux  = 2'b10;
        ld_reg = 1'b1;
        bus_in = 16'h6666;
        #1;
        n_checks++;
        if (dr !== 3'd6) begin
            n_fail++;
            $display("FAIL dr_stack: got %0d expected 6", dr);
        end
        step();
        drmux  = 2'b11;
        ir_sr1 = 3'd3;
        bus_in = 16'h3333;
        #1;
        n_checks++;
        if (dr !== 3'd3) begin
            n_fail++;
            $display("FAIL dr_sr1: got %0d expected 3", dr);
        end
        step();
        idle();
        // drmux wiggling with ld_reg low must not disturb anything.
        drmux = 2'b00;
        step();
        drmux = 2'b01;
        step();
        sr1 = 3'd6;
        sr2 = 3'd3;
        #1;
        n_checks++;
        if (sr1_data !== 16'h6666) begin
            n_fail++;
            $display("FAIL stack_write: got %h expected 6666", sr1_data);
        end
        n_checks++;
        if (sr2_data !== 16'h3333) begin
            n_fail++;
            $display("FAIL sr1_field_write: got %h expected 3333", sr2_data);
        end
        sr1 = 3'd7;
        sr2 = 3'd0;
        #1;
        n_checks++;
        if (sr1_data !== 16'h3000) begin
            n_fail++;
            $display("FAIL link_kept: got %h expected 3000", sr1_data);
        end
        n_checks++;
        if (sr2_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL r0_untouched: got %h expected 0000", sr2_data);
        end
    endtask

    task automatic test_cc;
        step();
        drmux  = 2'b00;
        ir_dr  = 3'd1;
        ld_reg = 1'b1;
        ld_cc  = 1'b1;
        bus_in = 16'h8001;
        step();
        bus_in = 16'h0000;
        step();
        #1;
        n_checks++;
        if (nzp !== 3'b100) begin
            n_fail++;
            $display("FAIL nzp_neg: got %b expected 100", nzp);
        end
        bus_in = 16'h0005;
        step();
        #1;
        n_checks++;
        if (nzp !== 3'b010) begin
            n_fail++;
            $display("FAIL nzp_zero: got %b expected 010", nzp);
        end
        idle();
        step();
        #1;
        n_checks++;
        if (nzp !== 3'b001) begin
            n_fail++;
            $display("FAIL nzp_pos: got %b expected 001", nzp);
        end
        // CC update alone: nzp changes, array does not.
        ld_cc  = 1'b1;
        bus_in = 16'hFFFF;
        step();
        idle();
        #1;
        n_checks++;
        if (wb_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL cc_only_pending: got %b expected 1", wb_pending);
        end
        step();
        sr1 = 3'd1;
        #1;
        n_checks++;
        if (nzp !== 3'b100) begin
            n_fail++;
            $display("FAIL nzp_cc_only: got %b expected 100", nzp);
        end
        n_checks++;
        if (sr1_data !== 16'h0005) begin
            n_fail++;
            $display("FAIL cc_only_array: got %h expected 0005", sr1_data);
        end
    endtask

    task automatic test_back_to_back;
        step();
        drmux  = 2'b00;
        ir_dr  = 3'd2;
        sr1    = 3'd2;
        sr2    = 3'd2;
        ld_reg = 1'b1;
        bus_in = 16'hAAAA;
        step();
        bus_in = 16'h5555;
        #1;
        n_checks++;
        if (sr1_data !== (BYPASS ? 16'hAAAA : 16'h0000)) begin
            n_fail++;
            $display("FAIL b2b_first_sr1: got %h expected %h", sr1_data,
                     BYPASS ? 16'hAAAA : 16'h0000);
        end
        step();
        idle();
        #1;
        n_checks++;
        if (sr2_data !== (BYPASS ? 16'h5555 : 16'hAAAA)) begin
            n_fail++;
            $display("FAIL b2b_second_sr2: got %h expected %h", sr2_data,
                     BYPASS ? 16'h5555 : 16'hAAAA);
        end
        step();
        #1;
        n_checks++;
        if (sr1_data !== 16'h5555) begin
            n_fail++;
            $display("FAIL b2b_final: got %h expected 5555", sr1_data);
        end
    endtask

    task automatic test_reset_abort;
        step();
        drmux  = 2'b00;
        ir_dr  = 3'd4;
        ld_reg = 1'b1;
        bus_in = 16'h1234;
        step();
        idle();
        #1;
        n_checks++;
        if (wb_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_staged: got %b expected 1", wb_pending);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (wb_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pending: got %b expected 0", wb_pending);
        end
        n_checks++;
        if (nzp !== 3'b010) begin
            n_fail++;
            $display("FAIL abort_nzp: got %b expected 010", nzp);
        end
        step();
        reset = 1'b0;
        step();
        sr1 = 3'd4;
        sr2 = 3'd6;
        #1;
        n_checks++;
        if (sr1_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL abort_r4: got %h expected 0000", sr1_data);
        end
        n_checks++;
        if (sr2_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL abort_r6_cleared: got %h expected 0000", sr2_data);
        end
    endtask

    initial begin
        test_reset();
        test_drmux();
        test_cc();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dr_writeback.md
DR_WRITEBACK -- requirements
Module: dr_writeback

Interface
REQ-001 Parameter: WIDTH, 16, data width of registers and bus.
REQ-002 Parameter: NREG, 8, number of general registers; SHALL be a power of two and at least 4; AW = log2(NREG).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports exactly as below.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ir_dr  in  AW  destination field (IR[11:9] equivalent).
REQ-007 ir_sr1  in  AW  base/source field (IR[8:6] equivalent).
REQ-008 drmux  in  2  destination select: 00 ir_dr, 01 NREG-1 (link), 10 NREG-2 (stack), 11 ir_sr1.
REQ-009 ld_reg  in  1  stage a register write this cycle.
REQ-010 ld_cc  in  1  stage a condition-code update this cycle.
REQ-011 bus_in  in  WIDTH  write data.
REQ-012 sr1, sr2  in  AW each  read addresses.
REQ-013 dr  out  AW  selected destination, combinational from drmux.
REQ-014 sr1_data, sr2_data  out  WIDTH each  combinational read data.
REQ-015 nzp  out  3  condition codes {N,Z,P}, registered.
REQ-016 wb_pending  out  1  staged write or CC update awaiting commit.

Function
REQ-017 dr SHALL follow the drmux table of REQ-008 with no register stage.
REQ-018 Stage: at each edge, wb_reg_v <= ld_reg, wb_cc_v <= ld_cc; when either is 1, wb_addr <= dr and wb_data <= bus_in; when both are 0, wb_addr/wb_data hold.
REQ-019 Commit: at each edge with wb_reg_v=1, regfile[wb_addr] <= wb_data; register array updated one edge after staging.
REQ-020 At each edge with wb_cc_v=1, nzp SHALL load 100 if wb_data[WIDTH-1]=1, 010 if wb_data=0, else 001.
REQ-021 Stage and commit on the same edge SHALL both occur (back-to-back writes sustain one per cycle, no stall).
REQ-022 Back-to-back writes to the same address SHALL leave the later data in the array.
REQ-023 wb_pending SHALL equal wb_reg_v OR wb_cc_v.
REQ-024 sr1_data/sr2_data SHALL be regfile[sr1]/regfile[sr2], subject to REQ-030.
REQ-025 drmux changes while ld_reg=0 SHALL have no effect on state.

Reset
REQ-026 While reset=1: all registers 0, wb_reg_v=0, wb_cc_v=0, wb_addr=0, wb_data=0, nzp=010, independent of clk.
REQ-027 Reset asserted with a write staged SHALL discard it; the array SHALL not be written.
REQ-028 After reset deassertion the first edge SHALL behave as REQ-018 with no commit.

Configuration
REQ-029 Macro DR_WRITEBACK_BYPASS_EN selects read forwarding.
REQ-030 Defined: if wb_reg_v=1 and wb_addr equals sr1 (sr2), sr1_data (sr2_data) SHALL be wb_data; not defined: array contents only, staged write invisible until after commit.

Verification
REQ-031 Reset, then read all registers -> every sr1_data/sr2_data = 0, nzp=010, wb_pending=0.
REQ-032 drmux=01, ld_reg=1, bus_in=16'h3000 one cycle -> wb_pending=1 next cycle; after second edge regfile[7]=16'h3000 via sr1=7; drmux=10 writes R6, drmux=11 with ir_sr1=3 writes R3.
REQ-033 ld_reg=ld_cc=1, bus_in=16'h8001 then 16'h0000 then 16'h0005 on consecutive cycles -> nzp 100, 010, 001 on successive edges after each commit; ld_cc alone with 16'hFFFF -> nzp=100, array unchanged.
REQ-034 ir_dr=2, bus_in=16'hAAAA then 16'h5555 back-to-back to R2, sr1=sr2=2 -> with BYPASS_EN reads 16'hAAAA then 16'h5555 in the cycles after staging; without, reads lag one cycle; final R2=16'h5555.
REQ-035 Stage write 16'h1234 to R4, assert reset before commit edge -> R4=0, wb_pending=0, nzp=010.
